wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter STAMP_W, default 16, cycle-stamp width in bits.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port reg_write  input  1  datapath register-file write enable (writer side).
REQ-006 SHALL have port write_reg  input  5  destination register index.
REQ-007 SHALL have port write_data  input  32  value written.
REQ-008 SHALL have port capture_en  input  1  1 = record writes; 0 = ignore reg_write.
REQ-009 SHALL have port out_ready  input  1  reader accepts head entry.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 SHALL have port out_reg  output  5  head entry register index.
REQ-012 SHALL have port out_data  output  32  head entry write value.
REQ-013 SHALL have port out_stamp  output  STAMP_W  head entry cycle stamp.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port clr_ovf  input  1  clears overflow and drop_count.
REQ-016 SHALL have port overflow  output  1  sticky: at least one write dropped.
REQ-017 SHALL have port drop_count  output  8  saturating count of dropped writes.

Function
REQ-018 SHALL run a free-running STAMP_W-bit stamp counter, +1 every cycle, wrapping all-ones to 0.
REQ-019 SHALL form a capture request in a cycle where reg_write=1 and capture_en=1, storing {stamp, write_reg, write_data} sampled that cycle.
REQ-020 SHALL push the request when count<DEPTH, or when count=DEPTH and a pop occurs the same cycle.
REQ-021 SHALL drop the request otherwise, setting overflow=1 and incrementing drop_count, saturating at 255.
REQ-022 SHALL pop the head when out_valid=1 and out_ready=1; out_ready with out_valid=0 has no effect.
REQ-023 SHALL assert out_valid exactly when count>0; out_reg/out_data/out_stamp SHALL reflect the head entry, held stable until popped.
REQ-024 SHALL have push-to-visible latency of 1 cycle: an entry captured at edge N is presented after edge N; no same-cycle bypass when empty.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-027 SHALL clear overflow and drop_count on clr_ovf=1, except that a drop in the same cycle SHALL set overflow=1 and drop_count=1.
REQ-028 SHALL drive out_reg/out_data/out_stamp to 0 when out_valid=0.

Reset
REQ-029 SHALL, on reset=1 at a rising clock edge, clear pointers, count=0, out_valid=0, stamp=0, overflow=0, drop_count=0; any push or pop that cycle is discarded.
REQ-030 SHALL NOT clear entry storage on reset; contents are unobservable while count=0.
REQ-031 SHALL resume capture on the first edge after reset deasserts; the stamp of that edge's capture is 0.

Configuration
REQ-032 SHALL honour macro WB_TRACE_SKIP_R0_EN: when defined, writes with write_reg=0 form no capture request (no push, no drop); when undefined, writes to register 0 are captured like any other.

Verification
REQ-033 Reset then reg_write=1, write_reg=3, write_data=0x0000002A for 1 cycle -> next cycle out_valid=1, out_reg=3, out_data=0x2A, out_stamp=0, count=1.
REQ-034 Fill 8 writes with out_ready=0, then 2 more -> count=8, overflow=1, drop_count=2; pop all 8 in order, then out_valid=0.
REQ-035 Full FIFO, one cycle with capture and out_ready=1 -> count stays 8, overflow stays 0, new entry appears last in order.
REQ-036 capture_en=0 with reg_write=1 for 5 cycles -> count=0, drop_count=0; stamp continues, wrapping 0xFFFF->0 after 65536 cycles.
REQ-037 write_reg=0, write_data=0x5 -> with WB_TRACE_SKIP_R0_EN count stays 0; without it, count=1, out_reg=0, out_data=5.
REQ-038 reset=1 mid-stream with count=5 and a push pending -> next cycle count=0, out_valid=0, overflow=0, stamp=0.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Bundle of the writer-side capture signals and the reader-side head-entry handshake
// for wb_trace_buffer. STAMP_W must match the buffer's STAMP_W.
interface wb_trace_buffer_if #(
  parameter int STAMP_W = 16
);
  logic               reg_write;
  logic [4:0]         write_reg;
  logic [31:0]        write_data;
  logic               capture_en;
  logic               out_ready;
  logic               out_valid;
  logic [4:0]         out_reg;
  logic [31:0]        out_data;
  logic [STAMP_W-1:0] out_stamp;

  modport master (
    output reg_write, write_reg, write_data, capture_en, out_ready,
    input  out_valid, out_reg, out_data, out_stamp
  );

  modport slave (
    input  reg_write, write_reg, write_data, capture_en, out_ready,
    output out_valid, out_reg, out_data, out_stamp
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Register-file write trace FIFO: cycle-stamped capture, head-entry readout, sticky overflow.
// Optional feature macro: WB_TRACE_SKIP_R0_EN (when defined, writes to register 0 are not traced).
module wb_trace_buffer #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  wb_trace_buffer_if.slave       bus,
  input  logic                   clr_ovf,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W-1:0] mem_stamp [DEPTH];
  logic [4:0]         mem_reg   [DEPTH];
  logic [31:0]        mem_data  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               capture_req;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

`ifdef WB_TRACE_SKIP_R0_EN
  assign capture_req = bus.reg_write && bus.capture_en && (bus.write_reg != 5'd0);
`else
  assign capture_req = bus.reg_write && bus.capture_en;
`endif

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push  = capture_req && (!full || pop);
  assign drop  = capture_req && !push;

  // Entry storage is deliberately not reset; it is unobservable while count is 0.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_stamp[wr_ptr] <= stamp;
      mem_reg[wr_ptr]   <= bus.write_reg;
      mem_data[wr_ptr]  <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stamp      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      // A drop coinciding with a clear restarts the accounting at one drop.
      if (clr_ovf) begin
        overflow   <= drop;
        drop_count <= drop ? 8'd1 : 8'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_reg   = empty ? 5'd0 : mem_reg[rd_ptr];
  assign bus.out_data  = empty ? 32'd0 : mem_data[rd_ptr];
  assign bus.out_stamp = empty ? '0 : mem_stamp[rd_ptr];
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_wb_trace_buffer;
  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             clr_ovf;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       drop_count;

  always #5 clock = ~clock;

  wb_trace_buffer_if #(.STAMP_W(STAMP_W)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  typedef struct {
    logic [STAMP_W-1:0] stamp;
    logic [4:0]         r;
    logic [31:0]        d;
  } entry_t;

  typedef struct {
    bit          rst;
    bit          rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    bit          cen;
    bit          rdy;
    bit          clr;
    bit          exp_valid;
    int          exp_count;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [15:0] exp_stamp;
    bit          exp_ovf;
    int          exp_drops;
  } vec_t;

  entry_t             model_q[$];
  logic [STAMP_W-1:0] model_stamp;
  bit                 model_ovf;
  int                 model_drops;
  vec_t               vecs[$];
  int                 tests_run = 0;
  int                 tests_failed = 0;

  task automatic check_value(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs presented before it.
  task automatic model_clock_edge();
    bit req;
    bit pop_m;
    bit room;
    bit drop_m;
    if (reset) begin
      model_q.delete();
      model_stamp = '0;
      model_ovf   = 1'b0;
      model_drops = 0;
      return;
    end
    req = bus.reg_write && bus.capture_en;
`ifdef WB_TRACE_SKIP_R0_EN
    if (bus.write_reg == 5'd0) req = 1'b0;
`endif
    pop_m  = (model_q.size() > 0) && bus.out_ready;
    room   = (model_q.size() < DEPTH) || pop_m;
    drop_m = req && !room;
    if (pop_m) void'(model_q.pop_front());
    if (req && room) model_q.push_back('{model_stamp, bus.write_reg, bus.write_data});
    if (clr_ovf) begin
      model_ovf   = drop_m;
      model_drops = drop_m ? 1 : 0;
    end else if (drop_m) begin
      model_ovf = 1'b1;
      if (model_drops < 255) model_drops++;
    end
    model_stamp = model_stamp + 1'b1;
  endtask

  task automatic check_output(input string tag);
    entry_t head;
    bit     has;
    has = (model_q.size() > 0);
    if (has) head = model_q[0];
    else     head = '{default: '0};
    check_value({tag, ".out_valid"},  bus.out_valid, has);
    check_value({tag, ".count"},      count,         model_q.size());
    check_value({tag, ".out_reg"},    bus.out_reg,   head.r);
    check_value({tag, ".out_data"},   bus.out_data,  head.d);
    check_value({tag, ".out_stamp"},  bus.out_stamp, head.stamp);
    check_value({tag, ".overflow"},   overflow,      model_ovf);
    check_value({tag, ".drop_count"}, drop_count,    model_drops);
  endtask

  task automatic apply_stimulus(input bit rst, input bit rw, input logic [4:0] wr,
                                input logic [31:0] wd, input bit cen, input bit rdy,
                                input bit clr, input bit do_check, input string tag);
    reset          = rst;
    bus.reg_write  = rw;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.capture_en = cen;
    bus.out_ready  = rdy;
    clr_ovf        = clr;
    @(posedge clock);
    model_clock_edge();
    #1;
    if (do_check) check_output(tag);
  endtask

  task automatic fill(input int n, input logic [31:0] base, input string tag);
    for (int i = 0; i < n; i++)
      apply_stimulus(0, 1, 5'(i + 1), base + 32'(i), 1, 0, 0, 1, tag);
  endtask

  task automatic add_vec(input bit rst, input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                         input bit cen, input bit rdy, input bit clr, input bit ev, input int ec,
                         input logic [4:0] er, input logic [31:0] ed, input logic [15:0] es,
                         input bit eo, input int edr);
    vec_t v;
    v = '{rst, rw, wr, wd, cen, rdy, clr, ev, ec, er, ed, es, eo, edr};
    vecs.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; clr_ovf = 1'b0;
    bus.reg_write = 1'b0; bus.write_reg = 5'd0; bus.write_data = 32'd0;
    bus.capture_en = 1'b0; bus.out_ready = 1'b0;
    model_q.delete(); model_stamp = '0; model_ovf = 1'b0; model_drops = 0;

    // Directed vectors: rst rw wr wd cen rdy clr | valid count reg data stamp ovf drops
    add_vec(1, 0, 0, 32'h0,  0, 0, 0,  0, 0, 0, 32'h0,  0, 0, 0);
    add_vec(0, 1, 3, 32'h2A, 1, 0, 0,  1, 1, 3, 32'h2A, 0, 0, 0);
    add_vec(0, 0, 0, 32'h0,  0, 1, 0,  0, 0, 0, 32'h0,  0, 0, 0);
    add_vec(0, 1, 7, 32'h11, 0, 0, 0,  0, 0, 0, 32'h0,  0, 0, 0);
`ifdef WB_TRACE_SKIP_R0_EN
    add_vec(0, 1, 0, 32'h5,  1, 0, 0,  0, 0, 0, 32'h0,  0, 0, 0);
`else
    add_vec(0, 1, 0, 32'h5,  1, 0, 0,  1, 1, 0, 32'h5,  3, 0, 0);
`endif
    add_vec(0, 1, 4, 32'h44, 1, 1, 0,  1, 1, 4, 32'h44, 4, 0, 0);
    add_vec(0, 0, 0, 32'h0,  0, 0, 1,  1, 1, 4, 32'h44, 4, 0, 0);
    add_vec(0, 1, 5, 32'h55, 1, 0, 0,  1, 2, 4, 32'h44, 4, 0, 0);
    add_vec(0, 0, 0, 32'h0,  0, 1, 0,  1, 1, 5, 32'h55, 6, 0, 0);
    add_vec(0, 0, 0, 32'h0,  0, 1, 0,  0, 0, 0, 32'h0,  0, 0, 0);
    add_vec(0, 0, 0, 32'h0,  0, 1, 0,  0, 0, 0, 32'h0,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply_stimulus(vecs[i].rst, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].cen,
                     vecs[i].rdy, vecs[i].clr, 1, {t, ".model"});
      check_value({t, ".out_valid"},  bus.out_valid, vecs[i].exp_valid);
      check_value({t, ".count"},      count,         vecs[i].exp_count);
      check_value({t, ".out_reg"},    bus.out_reg,   vecs[i].exp_reg);
      check_value({t, ".out_data"},   bus.out_data,  vecs[i].exp_data);
      check_value({t, ".out_stamp"},  bus.out_stamp, vecs[i].exp_stamp);
      check_value({t, ".overflow"},   overflow,      vecs[i].exp_ovf);
      check_value({t, ".drop_count"}, drop_count,    vecs[i].exp_drops);
    end

    // Fill past capacity, then drain in order.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, "ovf.reset");
    fill(10, 32'h100, "ovf.fill");
    check_value("ovf.count", count, 8);
    check_value("ovf.overflow", overflow, 1);
    check_value("ovf.drop_count", drop_count, 2);
    for (int i = 0; i < 8; i++) begin
      check_value("ovf.pop_data", bus.out_data, 32'h100 + 32'(i));
      apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1, "ovf.pop");
    end
    check_value("ovf.drained_valid", bus.out_valid, 0);

    // Capture into a full FIFO while the head leaves.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, "full.reset");
    fill(8, 32'h200, "full.fill");
    apply_stimulus(0, 1, 5'd31, 32'h2FF, 1, 1, 0, 1, "full.pushpop");
    check_value("full.count", count, 8);
    check_value("full.overflow", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check_value("full.order", bus.out_data, (i == 7) ? 32'h2FF : 32'h201 + 32'(i));
      apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1, "full.drain");
    end

    // Clear racing a drop, then a plain clear.
    fill(8, 32'h300, "clr.fill");
    apply_stimulus(0, 1, 5'd2, 32'h3A, 1, 0, 0, 1, "clr.drop1");
    apply_stimulus(0, 1, 5'd2, 32'h3B, 1, 0, 0, 1, "clr.drop2");
    check_value("clr.before", drop_count, 2);
    apply_stimulus(0, 1, 5'd2, 32'h3C, 1, 0, 1, 1, "clr.with_drop");
    check_value("clr.with_drop_ovf", overflow, 1);
    check_value("clr.with_drop_cnt", drop_count, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, "clr.plain");
    check_value("clr.plain_ovf", overflow, 0);
    check_value("clr.plain_cnt", drop_count, 0);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++)
      apply_stimulus(0, 1, 5'd6, 32'(i), 1, 0, 0, 1, "sat.drop");
    check_value("sat.drop_count", drop_count, 255);

    // Reset mid-stream with a push pending.
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1, "rst.pop");
    check_value("rst.count_before", count, 5);
    apply_stimulus(1, 1, 5'd8, 32'h88, 1, 0, 0, 1, "rst.mid");
    check_value("rst.count", count, 0);
    check_value("rst.valid", bus.out_valid, 0);
    check_value("rst.overflow", overflow, 0);
    apply_stimulus(0, 1, 5'd9, 32'h77, 1, 0, 0, 1, "rst.first");
    check_value("rst.first_stamp", bus.out_stamp, 0);

    // Disabled capture and stamp wrap.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, "wrap.reset");
    for (int i = 0; i < 65536; i++)
      apply_stimulus(0, 1, 5'(i), 32'(i), 0, 0, 0, (i % 4096) == 0, "wrap.idle");
    check_value("wrap.count", count, 0);
    check_value("wrap.drop_count", drop_count, 0);
    apply_stimulus(0, 1, 5'd10, 32'hA, 1, 0, 0, 1, "wrap.cap0");
    apply_stimulus(0, 1, 5'd11, 32'hB, 1, 0, 0, 1, "wrap.cap1");
    check_value("wrap.stamp_head", bus.out_stamp, 0);

    // Randomized traffic with varying reader pressure.
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, "rnd.reset");
    for (int phase = 0; phase < 15; phase++) begin
      int p;
      p = (phase % 3 == 0) ? 10 : ((phase % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 200; i++)
        apply_stimulus($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                       $urandom, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 99) < p, $urandom_range(0, 49) == 0, 1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
